dsp_mac_sequencer: RTL and testbench

//  Two-requester multiply-accumulate job controller for one DSP48A1 slice.

---
 rtl/dsp_mac_sequencer.sv | 160 ++++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// Two-requester MAC job controller feeding one DSP48A1 slice (A1/B1/M/P/OPMODE regs).
// Define DSP_SEQ_RR_EN for round-robin arbitration; otherwise req[0] has fixed priority.
module dsp_mac_sequencer #(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       gnt,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [17:0]      op_a,
    input  logic [17:0]      op_b,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ce,
    input  logic [47:0]      dsp_p,
    output logic             res_valid,
    output logic [47:0]      res_data,
    output logic             res_id
);

    localparam int DW = $clog2(PIPE_LAT + 1) + 1;

    localparam logic [7:0] OPM_ZERO = 8'b0000_0000;
    localparam logic [7:0] OPM_LOAD = 8'b0000_0001;
    localparam logic [7:0] OPM_ACC  = 8'b0000_1001;
    localparam logic [7:0] OPM_HOLD = 8'b0000_1000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] pick_len;
    logic [DW-1:0]    dcnt;
    logic             slot_v;
    logic             slot_first;
    logic             pick;
    logic             xfer;
    logic             last_xfer;

`ifdef DSP_SEQ_RR_EN
    logic rr_last;

    // rr_last=1 after reset so req[0] wins the first contention
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            rr_last <= 1'b1;
        end else if (state == DONE) begin
            rr_last <= gnt[1];
        end
    end

    assign pick = (req == 2'b11) ? ~rr_last : req[1];
`else
    assign pick = ~req[0];
`endif

    assign pick_len  = pick ? len1 : len0;
    assign op_ready  = (state == RUN);
    assign dsp_ce    = (state != IDLE);
    assign res_valid = (state == DONE);
    assign res_id    = (state == DONE) & gnt[1];
    assign res_data  = (state == DONE && len_q != '0) ? dsp_p : '0;
    assign xfer      = op_valid & op_ready;
    assign last_xfer = xfer && (cnt == len_q - LEN_W'(1));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_nx = (pick_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_xfer) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (dcnt == DW'(PIPE_LAT)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state      <= IDLE;
            gnt        <= '0;
            len_q      <= '0;
            cnt        <= '0;
            dcnt       <= '0;
            slot_v     <= 1'b0;
            slot_first <= 1'b0;
            dsp_a      <= '0;
            dsp_b      <= '0;
            dsp_opmode <= OPM_ZERO;
        end else begin
            state      <= state_nx;
            slot_v     <= xfer;
            slot_first <= xfer && (cnt == '0);
            dcnt       <= (state == DRAIN) ? dcnt + DW'(1) : '0;
            if (xfer) begin
                dsp_a <= op_a;
                dsp_b <= op_b;
            end
            // opmode trails its operand by one cycle to meet OPMODEREG at the P stage
            if (state_nx == IDLE) begin
                dsp_opmode <= OPM_ZERO;
            end else if (slot_v) begin
                dsp_opmode <= slot_first ? OPM_LOAD : OPM_ACC;
            end else if (cnt != '0) begin
                dsp_opmode <= OPM_HOLD;
            end else begin
                dsp_opmode <= OPM_ZERO;
            end
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= pick ? 2'b10 : 2'b01;
                        len_q <= pick_len;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        cnt <= cnt + LEN_W'(1);
                    end
                end
                DONE: begin
                    gnt <= '0;
                    cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP48A1 slice model.
// Checks results against a plain-arithmetic job model (define DSP_SEQ_RR_EN to match the RTL build).
module tb_dsp_mac_sequencer;

    localparam int LEN_W    = 8;
    localparam int PIPE_LAT = 3;

    logic             clk = 1'b0;
    logic             RSTN;
    logic [1:0]       req;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [1:0]       gnt;
    logic             op_valid;
    logic             op_ready;
    logic [17:0]      op_a;
    logic [17:0]      op_b;
    logic [17:0]      dsp_a;
    logic [17:0]      dsp_b;
    logic [7:0]       dsp_opmode;
    logic             dsp_ce;
    logic [47:0]      dsp_p;
    logic             res_valid;
    logic [47:0]      res_data;
    logic             res_id;

    dsp_mac_sequencer #(
        .LEN_W   (LEN_W),
        .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk       (clk),
        .RSTN      (RSTN),
        .req       (req),
        .len0      (len0),
        .len1      (len1),
        .gnt       (gnt),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .dsp_a     (dsp_a),
        .dsp_b     (dsp_b),
        .dsp_opmode(dsp_opmode),
        .dsp_ce    (dsp_ce),
        .dsp_p     (dsp_p),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    always #5 clk = ~clk;

    // DSP48A1 slice: A1REG=B1REG=MREG=PREG=OPMODEREG=1, X/Z muxes from OPMODE
    logic signed [17:0] a1;
    logic signed [17:0] b1;
    logic signed [35:0] m_r;
    logic [7:0]         opm_r;
    logic [47:0]        p_r;
    logic [47:0]        x_mux;
    logic [47:0]        z_mux;

    assign x_mux = (opm_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0;
    assign z_mux = (opm_r[3:2] == 2'b10) ? p_r : 48'd0;
    assign dsp_p = p_r;

    always @(posedge clk) begin
        if (dsp_ce) begin
            a1    <= dsp_a;
            b1    <= dsp_b;
            m_r   <= a1 * b1;
            opm_r <= dsp_opmode;
            p_r   <= z_mux + x_mux;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ncmp = 0;
    int nerr = 0;

    logic               mdl_last = 1'b1;
    int                 jlen[2];
    logic signed [17:0] ja[2][256];
    logic signed [17:0] jb[2][256];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_job(input int id, input int n);
        jlen[id] = n;
        for (int k = 0; k < n; k++) begin
            ja[id][k] = 18'($urandom);
            jb[id][k] = 18'($urandom);
        end
    endtask

    // serve the next job: predict winner, stream its pairs, check the result
    task automatic serve_one(input int gap, output logic [47:0] got);
        int          id;
        int          k;
        int          t;
        int          g;
        int          e_last;
        longint      s;
        logic [63:0] acc;
`ifdef DSP_SEQ_RR_EN
        if (req == 2'b11) id = mdl_last ? 0 : 1;
        else id = req[1] ? 1 : 0;
`else
        id = req[0] ? 0 : 1;
`endif
        s = 0;
        for (int i = 0; i < jlen[id]; i++) begin
            s += longint'(ja[id][i]) * longint'(jb[id][i]);
        end
        acc = s;
        len0 = 8'(jlen[0]);
        len1 = 8'(jlen[1]);
        t = 0;
        while (gnt === 2'b00 && t < 20) begin
            step();
            t++;
        end
        chk("grant", {62'd0, gnt}, (id == 1) ? 64'd2 : 64'd1);
        req[id] = 1'b0;
        if (jlen[id] == 0) begin
            chk("len0_ready", {63'd0, op_ready}, 64'd0);
        end else begin
            k = 0;
            t = 0;
            e_last = cyc;
            while (k < jlen[id] && t < 3000) begin
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                if (k > 0) begin
                    repeat (g) begin
                        op_valid = 1'b0;
                        op_a = 18'($urandom);
                        op_b = 18'($urandom);
                        step();
                        t++;
                    end
                end
                op_valid = 1'b1;
                op_a = ja[id][k];
                op_b = jb[id][k];
                chk("run_ready", {63'd0, op_ready}, 64'd1);
                step();
                k++;
                t++;
                e_last = cyc;
            end
            op_valid = 1'b0;
            chk("drain_ready", {63'd0, op_ready}, 64'd0);
            t = 0;
            while (res_valid !== 1'b1 && t < 20) begin
                step();
                t++;
            end
            chk("latency", 64'(cyc - e_last), 64'(PIPE_LAT + 1));
        end
        chk("res_valid", {63'd0, res_valid}, 64'd1);
        chk("res_data", {16'd0, res_data}, {16'd0, acc[47:0]});
        chk("res_id", {63'd0, res_id}, 64'(id));
        chk("gnt_hold", {62'd0, gnt}, (id == 1) ? 64'd2 : 64'd1);
        got = res_data;
        mdl_last = (id == 1);
        step();
        chk("res_pulse", {63'd0, res_valid}, 64'd0);
        chk("gnt_drop", {62'd0, gnt}, 64'd0);
        chk("idle_opmode", {56'd0, dsp_opmode}, 64'd0);
        chk("idle_ce", {63'd0, dsp_ce}, 64'd0);
    endtask

    initial begin
        logic [47:0] got;
        RSTN = 1'b0;
        req = 2'b00;
        len0 = '0;
        len1 = '0;
        op_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        repeat (3) step();
        chk("rst_gnt", {62'd0, gnt}, 64'd0);
        chk("rst_ready", {63'd0, op_ready}, 64'd0);
        chk("rst_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_opmode", {56'd0, dsp_opmode}, 64'd0);
        chk("rst_ce", {63'd0, dsp_ce}, 64'd0);
        chk("rst_dsp_a", {46'd0, dsp_a}, 64'd0);
        chk("rst_data", {16'd0, res_data}, 64'd0);
        RSTN = 1'b1;
        step();

        // reset during RUN aborts the job
        rand_job(0, 5);
        len0 = 8'd5;
        req = 2'b01;
        for (int t = 0; t < 20 && gnt === 2'b00; t++) step();
        op_valid = 1'b1;
        op_a = ja[0][0];
        op_b = jb[0][0];
        step();
        op_valid = 1'b0;
        #2;
        RSTN = 1'b0;
        #1;
        chk("abort_gnt", {62'd0, gnt}, 64'd0);
        chk("abort_ready", {63'd0, op_ready}, 64'd0);
        chk("abort_valid", {63'd0, res_valid}, 64'd0);
        chk("abort_opmode", {56'd0, dsp_opmode}, 64'd0);
        req = 2'b00;
        mdl_last = 1'b1;
        step();
        RSTN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("abort_no_res", {63'd0, res_valid}, 64'd0);
        end

        // back-to-back pairs, then the same job with 2-cycle gaps
        for (int gp = 0; gp <= 2; gp += 2) begin
            jlen[0] = 3;
            ja[0][0] = 18'sd2; jb[0][0] = 18'sd3;
            ja[0][1] = 18'sd4; jb[0][1] = 18'sd5;
            ja[0][2] = 18'sd6; jb[0][2] = 18'sd7;
            req = 2'b01;
            serve_one(gp, got);
            chk("sum68", {16'd0, got}, 64'd68);
        end

        // contention with req0 re-raised after its result
        jlen[0] = 2;
        jlen[1] = 2;
        ja[0][0] = 18'sd1; jb[0][0] = 18'sd1;
        ja[0][1] = 18'sd2; jb[0][1] = 18'sd2;
        ja[1][0] = 18'sd3; jb[1][0] = 18'sd3;
        ja[1][1] = 18'sd4; jb[1][1] = 18'sd4;
        req = 2'b11;
        serve_one(0, got);
        chk("arb_first", {16'd0, got}, 64'd5);
        req[0] = 1'b1;
        serve_one(0, got);
`ifdef DSP_SEQ_RR_EN
        chk("arb_second_rr", {16'd0, got}, 64'd25);
`else
        chk("arb_second_fixed", {16'd0, got}, 64'd5);
`endif
        serve_one(0, got);

        // zero-length job
        jlen[0] = 0;
        jlen[1] = 4;
        req = 2'b01;
        serve_one(0, got);
        chk("len0_data", {16'd0, got}, 64'd0);

        // signed operands
        jlen[0] = 2;
        ja[0][0] = -18'sd2; jb[0][0] = 18'sd3;
        ja[0][1] = 18'sd1;  jb[0][1] = 18'sd1;
        req = 2'b01;
        serve_one(0, got);
        chk("signed", {16'd0, got}, 64'h0000_FFFF_FFFF_FFFB);

        // longest job, full-range operands
        rand_job(1, 255);
        req = 2'b10;
        serve_one(-1, got);

        // randomized jobs and request patterns
        for (int j = 0; j < 10; j++) begin
            rand_job(0, int'($urandom_range(0, 12)));
            rand_job(1, int'($urandom_range(0, 12)));
            req = 2'($urandom_range(1, 3));
            while (req != 2'b00) serve_one(-1, got);
            repeat (int'($urandom_range(0, 2))) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
